triangle_assembler: RTL and testbench
=====================================

Name: triangle_assembler

Overview:
- Consumer side of the vertex FIFO that the geometry engine fills with screen-space vertices.
- Pops vertices one at a time and groups every three consecutive vertices into a triangle.
- Computes the doubled signed area and a screen-clamped bounding box for each triangle.
- Drops degenerate, back-facing and fully off-screen triangles; hands surviving triangles to the rasterizer over a valid/ready handshake.

Parameters:
- SCREEN_W, 320, screen width in pixels.
- SCREEN_H, 240, screen height in pixels.
- CULL_BACK, 1, 1 = drop triangles with negative area; 0 = keep them with v1/v2 swapped.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  one-cycle pulse: discard partially collected triangle
- i_fifo_empty  in  1  vertex FIFO empty
- o_fifo_rd_en  out  1  FIFO pop; data valid the cycle after
- i_fifo_x, i_fifo_y  in  32  Q16.16 screen coords; integer part [31:16]
- i_fifo_z  in  8  depth
- i_fifo_u, i_fifo_v  in  32  texture coords, passed through
- o_tri_valid  out  1  triangle available
- i_tri_ready  in  1  rasterizer accepts
- o_tri_x, o_tri_y  out  48  {v2,v1,v0} signed 16-bit integer coords
- o_tri_z  out  24  {z2,z1,z0}
- o_tri_u, o_tri_v  out  96  {v2,v1,v0}
- o_bbox_xmin, o_bbox_xmax  out  9  clamped to 0..SCREEN_W-1
- o_bbox_ymin, o_bbox_ymax  out  8  clamped to 0..SCREEN_H-1
- o_area2  out  35  signed doubled area
- o_tri_count, o_cull_count  out  16  emitted / dropped triangles, wrap at 2^16
- o_busy  out  1  high when the state is not S_FETCH or vertex index != 0

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs 0; state S_FETCH; vertex index 0; counters 0.
  - Reset mid-operation discards everything; outputs drop immediately, not at the next clock edge.
- State machine:
  - S_FETCH: if !i_fifo_empty, assert o_fifo_rd_en for exactly one cycle, go to S_CAPTURE. Otherwise idle; rd_en is never asserted while empty.
  - S_CAPTURE: latch x[31:16], y[31:16], z, u, v into slot idx. If idx==2, set idx=0 and go to S_SETUP; else idx++ and go to S_FETCH. Throughput is at most one vertex per 2 cycles.
  - S_SETUP (1 cycle): register two quantities.
    - area2 = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), with 17-bit differences, 34-bit products and a 35-bit result.
    - Raw min/max of x and y over the three vertices.
  - S_CULL (1 cycle), checks applied in order:
    - area2==0: drop.
    - xmax<0, xmin>SCREEN_W-1, ymax<0 or ymin>SCREEN_H-1: drop.
    - area2<0 and CULL_BACK=1: drop.
    - area2<0 and CULL_BACK=0: swap v1/v2 in all attribute slots and negate area2.
    - Drop: o_cull_count++, go to S_FETCH. Keep: clamp bbox, set o_tri_valid=1, go to S_OUTPUT.
  - S_OUTPUT:
    - Hold o_tri_valid and all o_tri_*/o_bbox_*/o_area2 stable until i_tri_ready.
    - On the handshake cycle: next cycle o_tri_valid=0, o_tri_count++, go to S_FETCH.
    - No FIFO reads while in S_OUTPUT.
- Latency: rd_en of third vertex to o_tri_valid = 4 cycles (CAPTURE, SETUP, CULL, then valid registered).
- i_flush handling:
  - In S_FETCH/S_CAPTURE: idx=0, go to S_FETCH; data arriving in that S_CAPTURE is discarded.
  - In S_SETUP/S_CULL/S_OUTPUT: ignored; the triangle is complete.
  - Flush has priority over capture in the same cycle.
- Clamping: coords are signed 16-bit. Values below 0 clamp to 0; values above SCREEN_W-1 / SCREEN_H-1 clamp to those limits.
- o_tri_x/y carry unclamped integer coords.
- Counters wrap to 0 silently.

Test Plan:
1. Vertices (10,10),(50,10),(10,40) as Q16.16, z=1,2,3 -> area2=+1200, bbox x 10..50, y 10..40, o_tri_z=0x030201, tri_count=1.
2. Order (10,10),(10,40),(50,10), CULL_BACK=1 -> no o_tri_valid, cull_count=1. With CULL_BACK=0 -> output order v0,(50,10),(10,40), area2=+1200.
3. Vertices (-20,-5),(400,10),(100,300) -> area2=126300, bbox xmin=0 xmax=319 ymin=0 ymax=239. Collinear (0,0),(5,5),(10,10) -> dropped, cull_count++.
4. Valid triangle with i_tri_ready low 10 cycles -> outputs stable, zero rd_en pulses; ready high -> one handshake, tri_count++, fetch resumes next cycle.
5. Push 2 vertices, pulse i_flush, push 3 more -> single triangle built from last 3 only. FIFO empty between vertices -> rd_en stays low, no duplicates.
6. Assert i_rst_n=0 while in S_OUTPUT -> o_tri_valid, counters and o_busy 0 immediately; after release, first triangle is built from fresh vertices.

Source files
------------

// File: rtl/triangle_assembler.sv
// -----------------------------------------------------------------------------
// triangle_assembler
//
// Consumer side of the screen-space vertex FIFO. Pops vertices one at a time,
// groups every three into a triangle, computes the doubled signed area and a
// screen-clamped bounding box, drops degenerate / back-facing / off-screen
// triangles and presents survivors to the rasterizer on a valid/ready port.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_flush                 one-cycle pulse: drop a partially collected triangle
//   i_fifo_empty            vertex FIFO empty
//   o_fifo_rd_en            FIFO pop; popped data is valid on the next cycle
//   i_fifo_x/y              Q16.16 screen coords (integer part used)
//   i_fifo_z, i_fifo_u/v    depth and texture coords, passed through
//   o_tri_valid/i_tri_ready triangle handshake
//   o_tri_x/y/z/u/v         packed {v2,v1,v0} attributes
//   o_bbox_*                bounding box clamped to the screen
//   o_area2                 signed doubled area (always positive when emitted)
//   o_tri_count/o_cull_count emitted / dropped triangle counters (wrapping)
//   o_busy                  a triangle is in progress
// -----------------------------------------------------------------------------
module triangle_assembler #(
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240,
    parameter bit CULL_BACK = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_fifo_empty,
    output logic         o_fifo_rd_en,
    input  logic [31:0]  i_fifo_x,
    input  logic [31:0]  i_fifo_y,
    input  logic [7:0]   i_fifo_z,
    input  logic [31:0]  i_fifo_u,
    input  logic [31:0]  i_fifo_v,
    output logic         o_tri_valid,
    input  logic         i_tri_ready,
    output logic [47:0]  o_tri_x,
    output logic [47:0]  o_tri_y,
    output logic [23:0]  o_tri_z,
    output logic [95:0]  o_tri_u,
    output logic [95:0]  o_tri_v,
    output logic [8:0]   o_bbox_xmin,
    output logic [8:0]   o_bbox_xmax,
    output logic [7:0]   o_bbox_ymin,
    output logic [7:0]   o_bbox_ymax,
    output logic [34:0]  o_area2,
    output logic [15:0]  o_tri_count,
    output logic [15:0]  o_cull_count,
    output logic         o_busy
);

    localparam logic signed [15:0] X_LIM = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] Y_LIM = 16'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_CAPTURE = 3'd1,
        S_SETUP   = 3'd2,
        S_CULL    = 3'd3,
        S_OUTPUT  = 3'd4
    } state_t;

    function automatic logic signed [15:0] min3(input logic signed [15:0] a,
                                               input logic signed [15:0] b,
                                               input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a,
                                               input logic signed [15:0] b,
                                               input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [8:0] clamp_x(input logic signed [15:0] v);
        if (v < 16'sd0) begin
            return 9'd0;
        end else if (v > X_LIM) begin
            return X_LIM[8:0];
        end else begin
            return v[8:0];
        end
    endfunction

    function automatic logic [7:0] clamp_y(input logic signed [15:0] v);
        if (v < 16'sd0) begin
            return 8'd0;
        end else if (v > Y_LIM) begin
            return Y_LIM[7:0];
        end else begin
            return v[7:0];
        end
    endfunction

    state_t             state_q;
    logic [1:0]         idx_q;
    logic signed [15:0] vx_q [3];
    logic signed [15:0] vy_q [3];
    logic [7:0]         vz_q [3];
    logic [31:0]        vu_q [3];
    logic [31:0]        vv_q [3];
    logic signed [34:0] area2_q;
    logic signed [15:0] xmin_q, xmax_q, ymin_q, ymax_q;

    logic         tri_valid_q;
    logic [47:0]  tri_x_q, tri_y_q;
    logic [23:0]  tri_z_q;
    logic [95:0]  tri_u_q, tri_v_q;
    logic [8:0]   bbox_xmin_q, bbox_xmax_q;
    logic [7:0]   bbox_ymin_q, bbox_ymax_q;
    logic [34:0]  area2_out_q;
    logic [15:0]  tri_count_q, cull_count_q;

    // Fractional coordinate bits are intentionally ignored.
    logic unused_frac_s;
    assign unused_frac_s = ^{i_fifo_x[15:0], i_fifo_y[15:0]};

    // Setup arithmetic: edge differences, cross products, doubled area, raw extents.
    logic signed [16:0] dx1_s, dy1_s, dx2_s, dy2_s;
    logic signed [33:0] prod_a_s, prod_b_s;
    logic signed [34:0] area2_d;
    logic signed [15:0] xmin_d, xmax_d, ymin_d, ymax_d;
    always_comb begin
        dx1_s    = $signed({vx_q[1][15], vx_q[1]}) - $signed({vx_q[0][15], vx_q[0]});
        dy1_s    = $signed({vy_q[1][15], vy_q[1]}) - $signed({vy_q[0][15], vy_q[0]});
        dx2_s    = $signed({vx_q[2][15], vx_q[2]}) - $signed({vx_q[0][15], vx_q[0]});
        dy2_s    = $signed({vy_q[2][15], vy_q[2]}) - $signed({vy_q[0][15], vy_q[0]});
        prod_a_s = $signed({{17{dx1_s[16]}}, dx1_s}) * $signed({{17{dy2_s[16]}}, dy2_s});
        prod_b_s = $signed({{17{dx2_s[16]}}, dx2_s}) * $signed({{17{dy1_s[16]}}, dy1_s});
        area2_d  = $signed({prod_a_s[33], prod_a_s}) - $signed({prod_b_s[33], prod_b_s});
        xmin_d   = min3(vx_q[0], vx_q[1], vx_q[2]);
        xmax_d   = max3(vx_q[0], vx_q[1], vx_q[2]);
        ymin_d   = min3(vy_q[0], vy_q[1], vy_q[2]);
        ymax_d   = max3(vy_q[0], vy_q[1], vy_q[2]);
    end

    // Cull decision and the (possibly winding-corrected) triangle to emit.
    logic        area_neg_s, offscreen_s, drop_s, swap_s;
    logic [47:0] tri_x_d, tri_y_d;
    logic [23:0] tri_z_d;
    logic [95:0] tri_u_d, tri_v_d;
    logic [34:0] area2_out_d;
    always_comb begin
        area_neg_s  = area2_q[34];
        offscreen_s = (xmax_q < 16'sd0) || (xmin_q > X_LIM) ||
                      (ymax_q < 16'sd0) || (ymin_q > Y_LIM);
        drop_s      = (area2_q == 35'sd0) || offscreen_s || (area_neg_s && CULL_BACK);
        // Back faces that are kept get v1/v2 exchanged so the winding turns positive.
        swap_s      = area_neg_s && !CULL_BACK;
        tri_x_d     = swap_s ? {vx_q[1], vx_q[2], vx_q[0]} : {vx_q[2], vx_q[1], vx_q[0]};
        tri_y_d     = swap_s ? {vy_q[1], vy_q[2], vy_q[0]} : {vy_q[2], vy_q[1], vy_q[0]};
        tri_z_d     = swap_s ? {vz_q[1], vz_q[2], vz_q[0]} : {vz_q[2], vz_q[1], vz_q[0]};
        tri_u_d     = swap_s ? {vu_q[1], vu_q[2], vu_q[0]} : {vu_q[2], vu_q[1], vu_q[0]};
        tri_v_d     = swap_s ? {vv_q[1], vv_q[2], vv_q[0]} : {vv_q[2], vv_q[1], vv_q[0]};
        area2_out_d = swap_s ? 35'(-area2_q) : area2_q;
    end

    // Assembly state machine with all registered state and outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_FETCH;
            idx_q        <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                vx_q[i] <= 16'sd0;
                vy_q[i] <= 16'sd0;
                vz_q[i] <= 8'd0;
                vu_q[i] <= 32'd0;
                vv_q[i] <= 32'd0;
            end
            area2_q      <= 35'sd0;
            xmin_q       <= 16'sd0;
            xmax_q       <= 16'sd0;
            ymin_q       <= 16'sd0;
            ymax_q       <= 16'sd0;
            tri_valid_q  <= 1'b0;
            tri_x_q      <= 48'd0;
            tri_y_q      <= 48'd0;
            tri_z_q      <= 24'd0;
            tri_u_q      <= 96'd0;
            tri_v_q      <= 96'd0;
            bbox_xmin_q  <= 9'd0;
            bbox_xmax_q  <= 9'd0;
            bbox_ymin_q  <= 8'd0;
            bbox_ymax_q  <= 8'd0;
            area2_out_q  <= 35'd0;
            tri_count_q  <= 16'd0;
            cull_count_q <= 16'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (i_flush) begin
                        idx_q <= 2'd0;
                    end else if (!i_fifo_empty) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // Flush wins: the vertex popped last cycle is thrown away.
                    if (i_flush) begin
                        idx_q   <= 2'd0;
                        state_q <= S_FETCH;
                    end else begin
                        for (int i = 0; i < 3; i++) begin
                            if (idx_q == 2'(i)) begin
                                vx_q[i] <= i_fifo_x[31:16];
                                vy_q[i] <= i_fifo_y[31:16];
                                vz_q[i] <= i_fifo_z;
                                vu_q[i] <= i_fifo_u;
                                vv_q[i] <= i_fifo_v;
                            end
                        end
                        if (idx_q == 2'd2) begin
                            idx_q   <= 2'd0;
                            state_q <= S_SETUP;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_SETUP: begin
                    area2_q <= area2_d;
                    xmin_q  <= xmin_d;
                    xmax_q  <= xmax_d;
                    ymin_q  <= ymin_d;
                    ymax_q  <= ymax_d;
                    state_q <= S_CULL;
                end
                S_CULL: begin
                    if (drop_s) begin
                        cull_count_q <= cull_count_q + 16'd1;
                        state_q      <= S_FETCH;
                    end else begin
                        tri_x_q     <= tri_x_d;
                        tri_y_q     <= tri_y_d;
                        tri_z_q     <= tri_z_d;
                        tri_u_q     <= tri_u_d;
                        tri_v_q     <= tri_v_d;
                        area2_out_q <= area2_out_d;
                        bbox_xmin_q <= clamp_x(xmin_q);
                        bbox_xmax_q <= clamp_x(xmax_q);
                        bbox_ymin_q <= clamp_y(ymin_q);
                        bbox_ymax_q <= clamp_y(ymax_q);
                        tri_valid_q <= 1'b1;
                        state_q     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (i_tri_ready) begin
                        tri_valid_q <= 1'b0;
                        tri_count_q <= tri_count_q + 16'd1;
                        state_q     <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                    idx_q   <= 2'd0;
                end
            endcase
        end
    end

    // The pop must react to the current empty flag, so it is decoded from the
    // state register; it is forced low during reset and on a flush cycle.
    assign o_fifo_rd_en = i_rst_n && (state_q == S_FETCH) && !i_fifo_empty && !i_flush;
    assign o_busy       = (state_q != S_FETCH) || (idx_q != 2'd0);

    assign o_tri_valid  = tri_valid_q;
    assign o_tri_x      = tri_x_q;
    assign o_tri_y      = tri_y_q;
    assign o_tri_z      = tri_z_q;
    assign o_tri_u      = tri_u_q;
    assign o_tri_v      = tri_v_q;
    assign o_bbox_xmin  = bbox_xmin_q;
    assign o_bbox_xmax  = bbox_xmax_q;
    assign o_bbox_ymin  = bbox_ymin_q;
    assign o_bbox_ymax  = bbox_ymax_q;
    assign o_area2      = area2_out_q;
    assign o_tri_count  = tri_count_q;
    assign o_cull_count = cull_count_q;

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed testbench for triangle_assembler. Instance 0 culls back faces,
// instance 1 keeps them with corrected winding. Each has its own FIFO model.
module tb_triangle_assembler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic        empty [2];
    logic        rd_en [2];
    logic [31:0] fx [2], fy [2], fu [2], fv [2];
    logic [7:0]  fz [2];
    logic        valid [2];
    logic        rdy [2];
    logic [47:0] tri_x [2], tri_y [2];
    logic [23:0] tri_z [2];
    logic [95:0] tri_u [2], tri_v [2];
    logic [8:0]  bxmin [2], bxmax [2];
    logic [7:0]  bymin [2], bymax [2];
    logic [34:0] area2 [2];
    logic [15:0] tcnt [2], ccnt [2];
    logic        busy [2];

    int vecs = 0;
    int errs = 0;

    // FIFO model storage
    logic [15:0] mx [2][64];
    logic [15:0] my [2][64];
    logic [7:0]  mz [2][64];
    int wp [2] = '{0, 0};
    int rp [2] = '{0, 0};
    int cyc = 0;
    int last_rd = 0;

    assign empty[0] = (rp[0] == wp[0]);
    assign empty[1] = (rp[1] == wp[1]);

    // FIFO read port: data appears the cycle after the pop.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en[0]) last_rd <= cyc;
        for (int k = 0; k < 2; k++) begin
            if (rd_en[k]) begin
                fx[k] <= {mx[k][rp[k] % 64], 16'h4000};
                fy[k] <= {my[k][rp[k] % 64], 16'hC000};
                fz[k] <= mz[k][rp[k] % 64];
                fu[k] <= {mx[k][rp[k] % 64], my[k][rp[k] % 64]};
                fv[k] <= ~{mx[k][rp[k] % 64], my[k][rp[k] % 64]};
                rp[k] <= rp[k] + 1;
            end
        end
    end

    triangle_assembler #(.SCREEN_W(320), .SCREEN_H(240), .CULL_BACK(1'b1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_fifo_empty(empty[0]),
        .o_fifo_rd_en(rd_en[0]), .i_fifo_x(fx[0]), .i_fifo_y(fy[0]), .i_fifo_z(fz[0]),
        .i_fifo_u(fu[0]), .i_fifo_v(fv[0]), .o_tri_valid(valid[0]), .i_tri_ready(rdy[0]),
        .o_tri_x(tri_x[0]), .o_tri_y(tri_y[0]), .o_tri_z(tri_z[0]), .o_tri_u(tri_u[0]),
        .o_tri_v(tri_v[0]), .o_bbox_xmin(bxmin[0]), .o_bbox_xmax(bxmax[0]),
        .o_bbox_ymin(bymin[0]), .o_bbox_ymax(bymax[0]), .o_area2(area2[0]),
        .o_tri_count(tcnt[0]), .o_cull_count(ccnt[0]), .o_busy(busy[0])
    );

    triangle_assembler #(.SCREEN_W(320), .SCREEN_H(240), .CULL_BACK(1'b0)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_fifo_empty(empty[1]),
        .o_fifo_rd_en(rd_en[1]), .i_fifo_x(fx[1]), .i_fifo_y(fy[1]), .i_fifo_z(fz[1]),
        .i_fifo_u(fu[1]), .i_fifo_v(fv[1]), .o_tri_valid(valid[1]), .i_tri_ready(rdy[1]),
        .o_tri_x(tri_x[1]), .o_tri_y(tri_y[1]), .o_tri_z(tri_z[1]), .o_tri_u(tri_u[1]),
        .o_tri_v(tri_v[1]), .o_bbox_xmin(bxmin[1]), .o_bbox_xmax(bxmax[1]),
        .o_bbox_ymin(bymin[1]), .o_bbox_ymax(bymax[1]), .o_area2(area2[1]),
        .o_tri_count(tcnt[1]), .o_cull_count(ccnt[1]), .o_busy(busy[1])
    );

    task automatic push(input int k, input logic [15:0] x, input logic [15:0] y,
                        input logic [7:0] z);
        mx[k][wp[k] % 64] = x;
        my[k][wp[k] % 64] = y;
        mz[k][wp[k] % 64] = z;
        wp[k] = wp[k] + 1;
    endtask

    task automatic wait_valid(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (valid[k]) ok = 1'b1;
        end
    endtask

    task automatic handshake(input int k);
        rdy[k] = 1'b1;
        @(negedge clk);
        rdy[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vecs++; if (valid[0] !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", valid[0]); end
        vecs++; if (tcnt[0] !== 16'd0) begin errs++; $display("FAIL reset_tcnt got %0d exp 0", tcnt[0]); end
        vecs++; if (ccnt[0] !== 16'd0) begin errs++; $display("FAIL reset_ccnt got %0d exp 0", ccnt[0]); end
        vecs++; if (busy[0] !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy[0]); end
        vecs++; if (area2[0] !== 35'd0) begin errs++; $display("FAIL reset_area got %0h exp 0", area2[0]); end
        rst_n = 1'b1;
        @(negedge clk);
        vecs++; if (rd_en[0] !== 1'b0) begin errs++; $display("FAIL idle_rd_en got %b exp 0", rd_en[0]); end
    endtask

    task automatic test_basic();
        bit ok;
        push(0, 16'd10, 16'd10, 8'd1);
        push(0, 16'd50, 16'd10, 8'd2);
        push(0, 16'd10, 16'd40, 8'd3);
        wait_valid(0, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL basic_timeout got no valid exp valid"); end
        vecs++; if (cyc - last_rd != 4) begin errs++; $display("FAIL basic_latency got %0d exp 4", cyc - last_rd); end
        vecs++; if (area2[0] !== 35'd1200) begin errs++; $display("FAIL basic_area got %0d exp 1200", area2[0]); end
        vecs++; if ({bxmin[0], bxmax[0], bymin[0], bymax[0]} !== {9'd10, 9'd50, 8'd10, 8'd40}) begin
            errs++; $display("FAIL basic_bbox got %0d %0d %0d %0d exp 10 50 10 40", bxmin[0], bxmax[0], bymin[0], bymax[0]); end
        vecs++; if (tri_z[0] !== 24'h030201) begin errs++; $display("FAIL basic_z got %h exp 030201", tri_z[0]); end
        vecs++; if (tri_x[0] !== 48'h000A_0032_000A) begin errs++; $display("FAIL basic_x got %h exp 000a0032000a", tri_x[0]); end
        vecs++; if (tri_y[0] !== 48'h0028_000A_000A) begin errs++; $display("FAIL basic_y got %h exp 0028000a000a", tri_y[0]); end
        vecs++; if (tri_u[0] !== 96'h000A0028_0032000A_000A000A) begin
            errs++; $display("FAIL basic_u got %h exp 000a00280032000a000a000a", tri_u[0]); end
        handshake(0);
        vecs++; if (valid[0] !== 1'b0) begin errs++; $display("FAIL basic_valid_drop got %b exp 0", valid[0]); end
        vecs++; if (tcnt[0] !== 16'd1) begin errs++; $display("FAIL basic_tcnt got %0d exp 1", tcnt[0]); end
    endtask

    task automatic test_backface();
        bit seen0 = 1'b0;
        bit seen1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push(k, 16'd10, 16'd10, 8'd1);
            push(k, 16'd10, 16'd40, 8'd2);
            push(k, 16'd50, 16'd10, 8'd3);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid[0]) seen0 = 1'b1;
            if (valid[1]) seen1 = 1'b1;
        end
        vecs++; if (seen0 !== 1'b0) begin errs++; $display("FAIL cull_back_valid got 1 exp 0"); end
        vecs++; if (ccnt[0] !== 16'd1) begin errs++; $display("FAIL cull_back_ccnt got %0d exp 1", ccnt[0]); end
        vecs++; if (seen1 !== 1'b1) begin errs++; $display("FAIL keep_back_valid got 0 exp 1"); end
        vecs++; if (area2[1] !== 35'd1200) begin errs++; $display("FAIL keep_back_area got %0d exp 1200", area2[1]); end
        vecs++; if (tri_x[1] !== 48'h000A_0032_000A) begin errs++; $display("FAIL keep_back_x got %h exp 000a0032000a", tri_x[1]); end
        vecs++; if (tri_y[1] !== 48'h0028_000A_000A) begin errs++; $display("FAIL keep_back_y got %h exp 0028000a000a", tri_y[1]); end
        vecs++; if (tri_z[1] !== 24'h020301) begin errs++; $display("FAIL keep_back_z got %h exp 020301", tri_z[1]); end
        handshake(1);
        vecs++; if (tcnt[1] !== 16'd1 || ccnt[1] !== 16'd0) begin
            errs++; $display("FAIL keep_back_counts got %0d/%0d exp 1/0", tcnt[1], ccnt[1]); end
    endtask

    task automatic test_clamp();
        bit ok;
        bit seen = 1'b0;
        push(0, -16'sd20, -16'sd5, 8'd4);
        push(0, 16'd400, 16'd10, 8'd5);
        push(0, 16'd100, 16'd300, 8'd6);
        wait_valid(0, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL clamp_timeout got no valid exp valid"); end
        vecs++; if (area2[0] !== 35'd126300) begin errs++; $display("FAIL clamp_area got %0d exp 126300", area2[0]); end
        vecs++; if ({bxmin[0], bxmax[0], bymin[0], bymax[0]} !== {9'd0, 9'd319, 8'd0, 8'd239}) begin
            errs++; $display("FAIL clamp_bbox got %0d %0d %0d %0d exp 0 319 0 239", bxmin[0], bxmax[0], bymin[0], bymax[0]); end
        vecs++; if (tri_x[0] !== 48'h0064_0190_FFEC) begin errs++; $display("FAIL clamp_x_unclamped got %h exp 00640190ffec", tri_x[0]); end
        handshake(0);
        vecs++; if (tcnt[0] !== 16'd2) begin errs++; $display("FAIL clamp_tcnt got %0d exp 2", tcnt[0]); end
        // collinear, then fully right of the screen
        push(0, 16'd0, 16'd0, 8'd1);
        push(0, 16'd5, 16'd5, 8'd2);
        push(0, 16'd10, 16'd10, 8'd3);
        push(0, 16'd400, 16'd10, 8'd1);
        push(0, 16'd500, 16'd10, 8'd2);
        push(0, 16'd400, 16'd50, 8'd3);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid[0]) seen = 1'b1;
        end
        vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL degenerate_valid got 1 exp 0"); end
        vecs++; if (ccnt[0] !== 16'd3) begin errs++; $display("FAIL degenerate_ccnt got %0d exp 3", ccnt[0]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int rds = 0;
        push(0, 16'd0, 16'd0, 8'd1);
        push(0, 16'd30, 16'd0, 8'd2);
        push(0, 16'd0, 16'd20, 8'd3);
        wait_valid(0, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL bp_timeout got no valid exp valid"); end
        push(0, 16'd100, 16'd100, 8'd7);
        push(0, 16'd120, 16'd100, 8'd8);
        push(0, 16'd100, 16'd130, 8'd9);
        for (int i = 0; i < 10; i++) begin
            if (rd_en[0]) rds++;
            vecs++;
            if (valid[0] !== 1'b1 || area2[0] !== 35'd600 || tri_x[0] !== 48'h0000_001E_0000) begin
                errs++; $display("FAIL bp_hold got v=%b a=%0d x=%h exp v=1 a=600 x=0000001e0000", valid[0], area2[0], tri_x[0]);
            end
            @(negedge clk);
        end
        vecs++; if (rds != 0) begin errs++; $display("FAIL bp_no_reads got %0d exp 0", rds); end
        handshake(0);
        vecs++; if (valid[0] !== 1'b0 || tcnt[0] !== 16'd3) begin
            errs++; $display("FAIL bp_handshake got v=%b cnt=%0d exp v=0 cnt=3", valid[0], tcnt[0]); end
        vecs++; if (rd_en[0] !== 1'b1) begin errs++; $display("FAIL bp_fetch_resume got %b exp 1", rd_en[0]); end
        wait_valid(0, ok);
        vecs++; if (!ok || area2[0] !== 35'd600 || tri_z[0] !== 24'h090807) begin
            errs++; $display("FAIL bp_second got ok=%b a=%0d z=%h exp 1 600 090807", ok, area2[0], tri_z[0]); end
        handshake(0);
        vecs++; if (tcnt[0] !== 16'd4) begin errs++; $display("FAIL bp_tcnt got %0d exp 4", tcnt[0]); end
    endtask

    task automatic test_flush();
        bit ok;
        int rds = 0;
        push(0, 16'd0, 16'd0, 8'hAA);
        push(0, 16'd200, 16'd200, 8'hBB);
        repeat (6) @(negedge clk);
        vecs++; if (busy[0] !== 1'b1) begin errs++; $display("FAIL flush_busy_before got %b exp 1", busy[0]); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vecs++; if (busy[0] !== 1'b0) begin errs++; $display("FAIL flush_busy_after got %b exp 0", busy[0]); end
        push(0, 16'd20, 16'd20, 8'd7);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rd_en[0]) rds++;
            @(negedge clk);
        end
        push(0, 16'd60, 16'd20, 8'd8);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rd_en[0]) rds++;
            @(negedge clk);
        end
        vecs++; if (rds != 0) begin errs++; $display("FAIL flush_empty_reads got %0d exp 0", rds); end
        push(0, 16'd20, 16'd50, 8'd9);
        wait_valid(0, ok);
        vecs++; if (!ok || tri_z[0] !== 24'h090807) begin errs++; $display("FAIL flush_z got ok=%b z=%h exp 090807", ok, tri_z[0]); end
        vecs++; if (tri_x[0] !== 48'h0014_003C_0014 || area2[0] !== 35'd1200) begin
            errs++; $display("FAIL flush_tri got x=%h a=%0d exp 0014003c0014 1200", tri_x[0], area2[0]); end
        handshake(0);
        vecs++; if (tcnt[0] !== 16'd5) begin errs++; $display("FAIL flush_tcnt got %0d exp 5", tcnt[0]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        push(0, 16'd10, 16'd10, 8'd1);
        push(0, 16'd50, 16'd10, 8'd2);
        push(0, 16'd10, 16'd40, 8'd3);
        wait_valid(0, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL rstmid_timeout got no valid exp valid"); end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++; if (valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errs++; $display("FAIL rstmid_async got v=%b busy=%b exp 0 0", valid[0], busy[0]); end
        vecs++; if (tcnt[0] !== 16'd0 || ccnt[0] !== 16'd0) begin
            errs++; $display("FAIL rstmid_counts got %0d/%0d exp 0/0", tcnt[0], ccnt[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 16'd5, 16'd5, 8'h11);
        push(0, 16'd25, 16'd5, 8'h22);
        push(0, 16'd5, 16'd15, 8'h33);
        wait_valid(0, ok);
        vecs++; if (!ok || tri_z[0] !== 24'h332211 || area2[0] !== 35'd200) begin
            errs++; $display("FAIL rstmid_fresh got ok=%b z=%h a=%0d exp 1 332211 200", ok, tri_z[0], area2[0]); end
        handshake(0);
        vecs++; if (tcnt[0] !== 16'd1) begin errs++; $display("FAIL rstmid_tcnt got %0d exp 1", tcnt[0]); end
    endtask

    initial begin
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        test_reset();
        test_basic();
        test_backface();
        test_clamp();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
